// File: rtl/add_approx_pipe.sv
// add_approx_pipe: pipelined unsigned approximate adder (exact / LOA / TRUNC).
// The exact reference sum travels with each beat. An error monitor accumulates
// |exact - approx| statistics at the output handshake.
module add_approx_pipe #(
   parameter int WIDTH  = 8,
   parameter int LOWER  = 4,
   parameter int STAGES = 2,
   parameter int ERR_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   input  logic             stat_clr,
   output logic [ERR_W-1:0] err_sum,
   output logic [WIDTH:0]   err_max,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int RW  = WIDTH + 1;
   localparam int EW1 = ERR_W + 1;

   // Ones in the approximated low field. This is zero when LOWER is 0.
   localparam logic [RW-1:0] LOW_MASK = ~({RW{1'b1}} << LOWER);
   // The top bit of the low field. It serves as the LOA carry tap and as the
   // half-range TRUNC compensation constant.
   localparam logic [RW-1:0] LOW_TOP  = (LOWER == 0) ? '0 : ((LOW_MASK >> 1) + RW'(1));

   logic [RW-1:0] a_x, b_x, a_hi, b_hi, hi_sum;
   logic [RW-1:0] exact_in, approx_in;
   logic          loa_carry;

   // Input-side arithmetic. The upper field is added as a shifted-down value
   // and then shifted back up. With this, LOWER == 0 and LOWER == WIDTH fall
   // out naturally.
   always_comb begin
      a_x       = {1'b0, a};
      b_x       = {1'b0, b};
      exact_in  = a_x + b_x;
      a_hi      = a_x >> LOWER;
      b_hi      = b_x >> LOWER;
      loa_carry = |(a_x & b_x & LOW_TOP);
      hi_sum    = '0;
      approx_in = exact_in;
      case (mode)
         2'b01: begin
            hi_sum    = a_hi + b_hi + {{(RW-1){1'b0}}, loa_carry};
            approx_in = (hi_sum << LOWER) | ((a_x | b_x) & LOW_MASK);
         end
         2'b10: begin
            hi_sum    = a_hi + b_hi;
            approx_in = (hi_sum << LOWER) | LOW_TOP;
         end
         default: ;  // exact, and reserved code 11 behaves as exact
      endcase
   end

   // Pipeline stage registers and their next-state values.
   logic          vld_q   [STAGES];
   logic          vld_d   [STAGES];
   logic [RW-1:0] sum_q   [STAGES];
   logic [RW-1:0] sum_d   [STAGES];
   logic [RW-1:0] exact_q [STAGES];
   logic [RW-1:0] exact_d [STAGES];
   logic          stall;

   // Backpressure freezes the whole pipe. Bubbles are kept, not squeezed out.
   assign stall     = vld_q[STAGES-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign vld_d[gi]   = in_valid;
            assign sum_d[gi]   = approx_in;
            assign exact_d[gi] = exact_in;
         end else begin : g_next
            assign vld_d[gi]   = vld_q[gi-1];
            assign sum_d[gi]   = sum_q[gi-1];
            assign exact_d[gi] = exact_q[gi-1];
         end
      end
   endgenerate

   // All stages advance together unless the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_q[i]   <= 1'b0;
            sum_q[i]   <= '0;
            exact_q[i] <= '0;
         end
      end else if (!stall) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_q[i]   <= vld_d[i];
            sum_q[i]   <= sum_d[i];
            exact_q[i] <= exact_d[i];
         end
      end
   end

   // Error monitor.
   logic [RW-1:0]    err_e;
   logic [EW1-1:0]   err_sum_ext;
   logic [ERR_W-1:0] err_sum_q, err_sum_d, err_cnt_q, err_cnt_d;
   logic [RW-1:0]    err_max_q, err_max_d;
   logic             out_fire;

   assign out_fire = vld_q[STAGES-1] & out_ready;

   // Absolute error of the delivered beat and the saturating statistics update.
   always_comb begin
      err_e       = (exact_q[STAGES-1] >= sum_q[STAGES-1]) ?
                    (exact_q[STAGES-1] - sum_q[STAGES-1]) :
                    (sum_q[STAGES-1] - exact_q[STAGES-1]);
      err_sum_ext = {1'b0, err_sum_q} + EW1'(err_e);
      err_sum_d   = err_sum_q;
      err_cnt_d   = err_cnt_q;
      err_max_d   = err_max_q;
      if (stat_clr) begin
         err_sum_d = '0;
         err_cnt_d = '0;
         err_max_d = '0;
      end else if (out_fire) begin
         err_sum_d = err_sum_ext[ERR_W] ? {ERR_W{1'b1}} : err_sum_ext[ERR_W-1:0];
         err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_W'(1);
         err_max_d = (err_e > err_max_q) ? err_e : err_max_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sum_q <= '0;
         err_cnt_q <= '0;
         err_max_q <= '0;
      end else begin
         err_sum_q <= err_sum_d;
         err_cnt_q <= err_cnt_d;
         err_max_q <= err_max_d;
      end
   end

   assign err_sum = err_sum_q;
   assign err_cnt = err_cnt_q;
   assign err_max = err_max_q;

endmodule
